// File: rtl/hdmi_packet_scheduler.sv
// Chooses the packet carried in each HDMI data-island slot (ACR > audio > aux > null) and
// holds its header/body stable for the slot. Optional macro: HDMI_AUDIO_CHANNEL_STATUS_EN.
module hdmi_packet_scheduler #(
  parameter logic [19:0] ACR_N      = 20'd6144,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [39:0] CS_WORD    = 40'h0
) (
  input  logic                          clk_pixel,
  input  logic                          reset_n,
  input  logic                          packet_load,
  input  logic                          audio_valid,
  output logic                          audio_ready,
  input  logic [23:0]                   audio_left,
  input  logic [23:0]                   audio_right,
  input  logic                          acr_req,
  input  logic [19:0]                   acr_cts,
  input  logic                          aux_req,
  input  logic [23:0]                   aux_header,
  input  logic [223:0]                  aux_sub,
  output logic [23:0]                   header,
  output logic [223:0]                  sub,
  output logic [1:0]                    packet_type,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {PKT_NULL = 2'd0, PKT_AUDIO = 2'd1, PKT_ACR = 2'd2, PKT_AUX = 2'd3} pkt_t;

  logic [23:0]   left_mem  [FIFO_DEPTH];
  logic [23:0]   right_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] level;
  logic          acr_pend, aux_pend;
  logic [19:0]   cts_q;
  logic [23:0]   aux_header_q;
  logic [223:0]  aux_sub_q;
  logic [7:0]    frame;
  pkt_t          pkt_q, sel;
  logic          push, pop;
  logic [2:0]    n_pop, n_eff;
  logic [3:0]    present, b_bits;
  logic [223:0]  audio_sub;
  logic [55:0]   acr_sp;

  // Frame index addition modulo the 192-frame IEC 60958 block.
  function automatic logic [7:0] frame_add(input logic [7:0] f, input logic [2:0] d);
    logic [8:0] s;
    s = {1'b0, f} + {6'b0, d};
    if (s >= 9'd192) s = s - 9'd192;
    return s[7:0];
  endfunction

  assign audio_ready = (level != LW'(FIFO_DEPTH));
  assign push        = audio_valid && audio_ready;
  assign fifo_level  = level;
  assign packet_type = pkt_q;

  always_comb begin
    n_pop = (level >= LW'(4)) ? 3'd4 : 3'(level);
    if (acr_pend)            sel = PKT_ACR;
    else if (level != '0)    sel = PKT_AUDIO;
    else if (aux_pend)       sel = PKT_AUX;
    else                     sel = PKT_NULL;
    pop   = packet_load && (sel == PKT_AUDIO);
    n_eff = pop ? n_pop : 3'd0;
  end

  // One slot per subpacket: sample k of this packet is the k-th oldest in the FIFO.
  for (genvar k = 0; k < 4; k++) begin : g_slot
    logic [AW-1:0] idx;
    logic [7:0]    f;
    logic [23:0]   l, r;
    logic          c, used;
    assign idx  = rd_ptr + AW'(k);
    assign f    = frame_add(frame, 3'(k));
    assign l    = left_mem[idx];
    assign r    = right_mem[idx];
    assign used = (3'(k) < n_pop);
`ifdef HDMI_AUDIO_CHANNEL_STATUS_EN
    localparam logic [63:0] CS_EXT = {24'b0, CS_WORD};
    assign c = (f < 8'd40) ? CS_EXT[f[5:0]] : 1'b0;
`else
    assign c = 1'b0;
`endif
    assign audio_sub[56*k +: 56] = used ? {^{r, c}, c, 2'b00, ^{l, c}, c, 2'b00, r, l} : 56'd0;
    assign present[k] = used;
    assign b_bits[k]  = used && (f == 8'd0);
  end

`ifndef HDMI_AUDIO_CHANNEL_STATUS_EN
  logic unused_cs;
  assign unused_cs = ^CS_WORD;
`endif

  assign acr_sp = {ACR_N[7:0], ACR_N[15:8], 4'h0, ACR_N[19:16],
                   cts_q[7:0], cts_q[15:8], 4'h0, cts_q[19:16], 8'h00};

  // NOTE: sample storage has no reset; entries are only ever read below the fill level.
  always_ff @(posedge clk_pixel) begin
    if (push) begin
      left_mem[wr_ptr]  <= audio_left;
      right_mem[wr_ptr] <= audio_right;
    end
  end

  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      level        <= '0;
      frame        <= '0;
      acr_pend     <= 1'b0;
      aux_pend     <= 1'b0;
      cts_q        <= '0;
      aux_header_q <= '0;
      aux_sub_q    <= '0;
      pkt_q        <= PKT_NULL;
      header       <= '0;
      sub          <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr <= rd_ptr + AW'(n_eff);
      level  <= level + LW'(push) - LW'(n_eff);
      frame  <= frame_add(frame, n_eff);

      // A new request outranks the clear from a simultaneous load.
      if (acr_req) begin
        acr_pend <= 1'b1;
        cts_q    <= acr_cts;
      end else if (packet_load && sel == PKT_ACR) begin
        acr_pend <= 1'b0;
      end

      if (aux_req) begin
        aux_pend     <= 1'b1;
        aux_header_q <= aux_header;
        aux_sub_q    <= aux_sub;
      end else if (packet_load && sel == PKT_AUX) begin
        aux_pend <= 1'b0;
      end

      if (packet_load) begin
        pkt_q <= sel;
        case (sel)
          PKT_ACR: begin
            header <= 24'h000001;
            sub    <= {4{acr_sp}};
          end
          PKT_AUDIO: begin
            header <= {b_bits, 4'h0, 4'h0, present, 8'h02};
            sub    <= audio_sub;
          end
          PKT_AUX: begin
            header <= aux_header_q;
            sub    <= aux_sub_q;
          end
          default: begin
            header <= '0;
            sub    <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hdmi_packet_scheduler.sv
// Self-checking bench for hdmi_packet_scheduler: vector table plus a packet scoreboard fed by a
// behavioural model of the FIFO, pending flags and frame index.
module tb_hdmi_packet_scheduler;

  localparam int          DEPTH = 8;
  localparam logic [19:0] N     = 20'd6144;
  localparam logic [39:0] CS    = 40'h1;
`ifdef HDMI_AUDIO_CHANNEL_STATUS_EN
  localparam bit CS_EN = 1'b1;
`else
  localparam bit CS_EN = 1'b0;
`endif

  logic         clk_pixel, reset_n, packet_load, audio_valid, audio_ready;
  logic [23:0]  audio_left, audio_right;
  logic         acr_req, aux_req;
  logic [19:0]  acr_cts;
  logic [23:0]  aux_header, header;
  logic [223:0] aux_sub, sub;
  logic [1:0]   packet_type;
  logic [3:0]   fifo_level;

  hdmi_packet_scheduler #(.ACR_N(N), .FIFO_DEPTH(DEPTH), .CS_WORD(CS)) dut (
    .clk_pixel(clk_pixel), .reset_n(reset_n), .packet_load(packet_load),
    .audio_valid(audio_valid), .audio_ready(audio_ready),
    .audio_left(audio_left), .audio_right(audio_right),
    .acr_req(acr_req), .acr_cts(acr_cts),
    .aux_req(aux_req), .aux_header(aux_header), .aux_sub(aux_sub),
    .header(header), .sub(sub), .packet_type(packet_type), .fifo_level(fifo_level)
  );

  initial clk_pixel = 1'b0;
  always #5 clk_pixel = ~clk_pixel;

  typedef struct packed { logic [23:0] l; logic [23:0] r; } smp_t;
  typedef struct { logic [1:0] t; logic [23:0] h; logic [223:0] s; } pkt_exp_t;
  typedef struct { int pushes; bit acr; bit aux; bit load; int exp_type; int exp_level; } vec_t;

  smp_t         mq[$];
  pkt_exp_t     sb[$];
  logic [7:0]   m_frame;
  bit           m_acr, m_aux;
  logic [19:0]  m_cts, cur_cts;
  logic [23:0]  m_ah, cur_ah;
  logic [223:0] m_as, cur_as;
  int           sample_no;
  int           errors = 0;
  int           checks = 0;
  vec_t         vecs[9];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic model_c(input logic [7:0] f);
    logic [63:0] cs64;
    cs64 = {24'b0, CS};
    return CS_EN && (f < 8'd40) && cs64[f[5:0]];
  endfunction

  task automatic model_load();
    pkt_exp_t e;
    smp_t s;
    logic [3:0] b, pres;
    logic c, pl, pr;
    int n;
    e.t = 2'd0; e.h = '0; e.s = '0; b = '0; pres = '0;
    if (m_acr) begin
      e.t = 2'd2;
      e.h = 24'h000001;
      e.s = {4{N[7:0], N[15:8], 4'h0, N[19:16], m_cts[7:0], m_cts[15:8], 4'h0, m_cts[19:16], 8'h00}};
      m_acr = 1'b0;
    end else if (mq.size() > 0) begin
      e.t = 2'd1;
      n = (mq.size() > 4) ? 4 : mq.size();
      for (int k = 0; k < n; k++) begin
        s  = mq.pop_front();
        c  = model_c(m_frame);
        pl = ^{s.l, c};
        pr = ^{s.r, c};
        e.s[56*k +: 56] = {pr, c, 1'b0, 1'b0, pl, c, 1'b0, 1'b0, s.r, s.l};
        pres[k] = 1'b1;
        b[k]    = (m_frame == 8'd0);
        m_frame = (m_frame == 8'd191) ? 8'd0 : m_frame + 8'd1;
      end
      e.h = {b, 4'h0, 4'h0, pres, 8'h02};
    end else if (m_aux) begin
      e.t = 2'd3;
      e.h = m_ah;
      e.s = m_as;
      m_aux = 1'b0;
    end
    sb.push_back(e);
  endtask

  task automatic clear_inputs();
    packet_load = 1'b0; audio_valid = 1'b0; acr_req = 1'b0; aux_req = 1'b0;
  endtask

  // One clock of stimulus; the model advances as the DUT should on the same edge.
  task automatic step(input bit valid, input bit acr, input bit aux, input bit load);
    pkt_exp_t e;
    bit ready;
    audio_valid = valid;
    audio_left  = 24'h000001 + 24'(sample_no);
    audio_right = 24'h800000 + 24'(sample_no);
    acr_req = acr; acr_cts = cur_cts;
    aux_req = aux; aux_header = cur_ah; aux_sub = cur_as;
    packet_load = load;
    ready = (mq.size() < DEPTH);
    if (load) model_load();
    if (valid && ready) begin
      mq.push_back({audio_left, audio_right});
      sample_no++;
    end
    if (acr) begin m_acr = 1'b1; m_cts = cur_cts; end
    if (aux) begin m_aux = 1'b1; m_ah = cur_ah; m_as = cur_as; end
    @(posedge clk_pixel);
    #1;
    clear_inputs();
    if (load) begin
      e = sb.pop_front();
      check("sb type", packet_type, e.t);
      check("sb header", header, e.h);
      check("sb sub", sub, e.s);
    end
    check("level", fifo_level, mq.size());
    check("ready", audio_ready, mq.size() < DEPTH);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    clear_inputs();
    #3;
    mq.delete(); sb.delete();
    m_frame = '0; m_acr = 1'b0; m_aux = 1'b0;
    @(negedge clk_pixel);
    reset_n = 1'b1;
    @(posedge clk_pixel);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    clear_inputs();
    audio_left = '0; audio_right = '0; acr_cts = '0; aux_header = '0; aux_sub = '0;
    sample_no = 0;
    cur_cts = 20'h12345;
    cur_ah  = 24'h0D0282;
    cur_as  = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};

    vecs[0] = '{0, 0, 0, 1, 0, 0};
    vecs[1] = '{0, 1, 0, 1, 2, 0};
    vecs[2] = '{6, 0, 0, 1, 1, 2};
    vecs[3] = '{0, 0, 0, 1, 1, 0};
    vecs[4] = '{1, 1, 1, 1, 2, 1};
    vecs[5] = '{0, 0, 0, 1, 1, 0};
    vecs[6] = '{0, 0, 0, 1, 3, 0};
    vecs[7] = '{0, 0, 0, 1, 0, 0};
    vecs[8] = '{8, 0, 0, 0, -1, 8};

    #12;
    do_reset();
    check("reset header", header, 24'h0);
    check("reset sub", sub, 224'h0);
    check("reset type", packet_type, 2'd0);
    check("reset level", fifo_level, 4'd0);
    check("reset ready", audio_ready, 1'b1);

    for (int i = 0; i < 9; i++) begin
      if (i == 4) cur_cts = 20'h0ABCD;
      repeat (vecs[i].pushes) step(1'b1, 1'b0, 1'b0, 1'b0);
      if (vecs[i].acr || vecs[i].aux) step(1'b0, vecs[i].acr, vecs[i].aux, 1'b0);
      if (vecs[i].load) step(1'b0, 1'b0, 1'b0, 1'b1);
      if (vecs[i].exp_type >= 0) check($sformatf("vec%0d type", i), packet_type, vecs[i].exp_type);
      check($sformatf("vec%0d level", i), fifo_level, vecs[i].exp_level);
      if (i == 1) begin
        check("acr header", header, 24'h000001);
        check("acr subpacket", sub[55:0], 56'h00180045230100);
      end
      if (i == 2) check("audio hb1 full", header[11:8], 4'hF);
      if (i == 3) begin
        check("audio hb1 two", header[11:8], 4'h3);
        check("audio unused sp", sub[223:112], 112'h0);
      end
    end

    // Full FIFO refuses the push offered alongside the load.
    check("full not ready", audio_ready, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    check("load on full level", fifo_level, 4'd4);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    check("load+push level", fifo_level, 4'd1);
    check("load+push ready", audio_ready, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // ACR request coinciding with the load that clears it keeps the flag set.
    cur_cts = 20'hFEDCB;
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    check("acr same-cycle type", packet_type, 2'd2);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("acr kept pending", packet_type, 2'd2);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("acr cleared", packet_type, 2'd0);

    // Repeated aux request overwrites data; still a single packet.
    step(1'b0, 1'b0, 1'b1, 1'b0);
    cur_ah = 24'h0A0184;
    cur_as = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("aux overwrite header", header, 24'h0A0184);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("aux once", packet_type, 2'd0);

    // Frame-index wrap: 49 packets of 4 samples, start-of-block on samples 0 and 192.
    do_reset();
    for (int r = 0; r < 49; r++) begin
      repeat (4) step(1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b1);
      check($sformatf("hb2 pkt%0d", r), header[23:16], (r == 0 || r == 48) ? 8'h10 : 8'h00);
      check($sformatf("c_l pkt%0d", r), sub[50], CS_EN && (r == 0 || r == 48));
    end

    // Asynchronous reset in the middle of a slot clears outputs at once.
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    check("pre-reset type", packet_type, 2'd2);
    #2;
    reset_n = 1'b0;
    #1;
    check("async reset header", header, 24'h0);
    check("async reset type", packet_type, 2'd0);
    check("async reset level", fifo_level, 4'd0);
    do_reset();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
